// File: rtl/bignum_pkg.sv
// Shared types for the bignum datapath: comparator verdict encoding and the
// conditional-subtractor state machine encoding.
package bignum_pkg;

    typedef enum logic [1:0] {
        CMP_NULL = 2'b00,
        CMP_LT   = 2'b01,
        CMP_GT   = 2'b10,
        CMP_EQ   = 2'b11
    } cmp_result_t;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_DRAIN,
        ST_FLUSH
    } condsub_state_t;

    // A >= B means the reduction applies; a NULL verdict never subtracts.
    function automatic logic is_subtract(cmp_result_t verdict);
        return (verdict == CMP_GT) || (verdict == CMP_EQ);
    endfunction

endpackage

// File: rtl/condsub_buffer.sv
// Simple dual-port block buffer holding {A,B} pairs; one write port, one read
// port with a single registered read stage so it maps onto block RAM.
module condsub_buffer #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 64,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and its read register carry no reset; a reset would stop
    // block-RAM inference, and every read is preceded by a write of that entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/conditional_subtractor.sv
// Block-serial conditional subtractor: buffers an A/B block stream, latches the
// comparator verdict, then streams A-B (A >= B) or A, LSB block first.
// Optional check logic on error_out is enabled by defining CONDSUB_ERROR_CHECK_EN.
module conditional_subtractor
    import bignum_pkg::*;
#(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_BLOCKS    = 128
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     valid_in,
    input  logic [REGISTER_SIZE-1:0] block_numA_in,
    input  logic [REGISTER_SIZE-1:0] block_numB_in,
    input  logic [1:0]               comparison_result_in,
    input  logic                     end_comparison_in,
    output logic                     in_ready_out,
    output logic [REGISTER_SIZE-1:0] data_out,
    output logic                     data_valid_out,
    output logic                     data_last_out,
    input  logic                     ready_in,
    output logic                     subtracted_out,
    output logic                     error_out
);

    localparam int AW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int DW = 2 * REGISTER_SIZE;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_BLOCKS - 1);

    condsub_state_t state_q, state_d;
    cmp_result_t    verdict;

    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic           sub_q, borrow_q, beat_borrow_q;
    logic           rd_valid_q, rd_last_q;
    logic [DW-1:0]  rd_data;

    logic accept, accept_end, beat_xfer, out_free, rd_issue, load_out, borrow_in;
    logic [REGISTER_SIZE-1:0] a_blk, b_blk;
    logic [REGISTER_SIZE:0]   diff;

    assign verdict    = cmp_result_t'(comparison_result_in);
    assign accept     = (state_q == ST_FILL) && valid_in;
    assign accept_end = accept && end_comparison_in;
    assign beat_xfer  = data_valid_out && ready_in;
    assign out_free   = !data_valid_out || ready_in;
    // A read is issued only when its data will have somewhere to go next cycle.
    assign rd_issue   = (state_q == ST_DRAIN) && (!rd_valid_q || out_free);
    assign load_out   = rd_valid_q && out_free;

    assign a_blk = rd_data[DW-1:REGISTER_SIZE];
    assign b_blk = rd_data[REGISTER_SIZE-1:0];

    // The beat leaving this edge supplies the borrow for the beat being loaded.
    assign borrow_in = beat_xfer ? beat_borrow_q : borrow_q;
    assign diff      = {1'b0, a_blk} - {1'b0, b_blk}
                     - {{REGISTER_SIZE{1'b0}}, borrow_in};

    condsub_buffer #(
        .DEPTH (NUM_BLOCKS),
        .WIDTH (DW),
        .AW    (AW)
    ) u_buffer (
        .clk     (clk_in),
        .wr_en   (accept),
        .wr_addr (wr_ptr_q),
        .wr_data ({block_numA_in, block_numB_in}),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FILL:  if (accept_end) state_d = ST_DRAIN;
            ST_DRAIN: if (rd_issue && (rd_ptr_q == LAST_IDX)) state_d = ST_FLUSH;
            ST_FLUSH: if (beat_xfer && data_last_out) state_d = ST_FILL;
            default:  state_d = ST_FILL;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= ST_FILL;
            in_ready_out   <= 1'b1;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            sub_q          <= 1'b0;
            borrow_q       <= 1'b0;
            beat_borrow_q  <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_last_q      <= 1'b0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
            data_last_out  <= 1'b0;
            subtracted_out <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_out <= (state_d == ST_FILL);

            if (accept) begin
                wr_ptr_q <= (accept_end || (wr_ptr_q == LAST_IDX)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (accept_end) begin
                sub_q <= is_subtract(verdict);
            end

            if (rd_issue) begin
                rd_ptr_q  <= (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
                rd_last_q <= (rd_ptr_q == LAST_IDX);
            end
            if (rd_issue) begin
                rd_valid_q <= 1'b1;
            end else if (load_out) begin
                rd_valid_q <= 1'b0;
            end

            if (accept_end) begin
                borrow_q <= 1'b0;
            end else if (beat_xfer) begin
                borrow_q <= beat_borrow_q;
            end

            if (load_out) begin
                data_out       <= sub_q ? diff[REGISTER_SIZE-1:0] : a_blk;
                beat_borrow_q  <= sub_q & diff[REGISTER_SIZE];
                data_valid_out <= 1'b1;
                data_last_out  <= rd_last_q;
                subtracted_out <= sub_q;
            end else if (beat_xfer) begin
                data_valid_out <= 1'b0;
                data_last_out  <= 1'b0;
            end
        end
    end

`ifdef CONDSUB_ERROR_CHECK_EN
    logic err_event;

    assign err_event = (valid_in && !in_ready_out)
                     || (accept_end && (verdict == CMP_NULL))
                     || (beat_xfer && data_last_out && subtracted_out && beat_borrow_q);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            error_out <= 1'b0;
        end else if (err_event) begin
            error_out <= 1'b1;
        end
    end
`else
    assign error_out = 1'b0;
`endif

endmodule
